// File: rtl/elastic_pe.sv
// Elastic processing element: NUM_IN buffered valid/ready input channels feeding a
// configurable ALU with accumulate mode, one registered output, serial config chain.
module elastic_pe #(
  parameter int WIDTH      = 32,
  parameter int NUM_IN     = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int SEL_W      = $clog2(NUM_IN + 1),
  parameter int CFG_W      = 12 + 2 * SEL_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    config_en,
  input  logic                    config_in,
  output logic                    config_out,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int SH_W  = $clog2(WIDTH);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_MUL  = 4'd2,
    OP_AND  = 4'd3,
    OP_OR   = 4'd4,
    OP_XOR  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_PASS = 4'd8,
    OP_SMIN = 4'd9,
    OP_ACC  = 4'd10
  } op_e;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1;
  // valid never depends on ready, and in_ready depends only on FIFO occupancy.

  logic [CFG_W-1:0] r_cfg;
  logic [WIDTH-1:0] r_acc;
  logic [7:0]       r_cnt;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;

  op_e              w_op;
  logic [SEL_W-1:0] w_sel_a;
  logic [SEL_W-1:0] w_sel_b;
  logic [7:0]       w_acc_len;

  assign w_op       = op_e'(r_cfg[3:0]);
  assign w_sel_a    = r_cfg[4 +: SEL_W];
  assign w_sel_b    = r_cfg[4 + SEL_W +: SEL_W];
  assign w_acc_len  = r_cfg[4 + 2*SEL_W +: 8];
  assign config_out = r_cfg[CFG_W-1];

  logic [WIDTH-1:0]  w_head [NUM_IN];
  logic [NUM_IN-1:0] w_empty;
  logic [NUM_IN-1:0] w_full;
  logic [NUM_IN-1:0] w_push;
  logic [NUM_IN-1:0] w_pop;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_fifo
    logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_count;

    assign w_empty[g]  = (r_count == '0);
    assign w_full[g]   = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    // Ready is held low while reset is asserted so nothing is accepted into a clearing FIFO.
    assign in_ready[g] = reset & ~w_full[g];
    assign w_push[g]   = in_valid[g] & in_ready[g];
    assign w_head[g]   = r_mem[r_rptr];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
        for (int k = 0; k < FIFO_DEPTH; k++) r_mem[k] <= '0;
      end else begin
        if (w_push[g]) begin
          r_mem[r_wptr] <= in_data[g*WIDTH +: WIDTH];
          r_wptr        <= r_wptr + 1'b1;
        end
        if (w_pop[g]) r_rptr <= r_rptr + 1'b1;
        case ({w_push[g], w_pop[g]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Selects at or beyond NUM_IN read as a constant zero that is always available.
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_a_ok;
  logic             w_b_ok;

  always_comb begin
    w_a    = '0;
    w_b    = '0;
    w_a_ok = 1'b1;
    w_b_ok = 1'b1;
    for (int i = 0; i < NUM_IN; i++) begin
      if (int'(w_sel_a) == i) begin
        w_a    = w_head[i];
        w_a_ok = ~w_empty[i];
      end
      if (int'(w_sel_b) == i) begin
        w_b    = w_head[i];
        w_b_ok = ~w_empty[i];
      end
    end
  end

  logic [WIDTH-1:0] w_result;
  logic [WIDTH-1:0] w_acc_sum;

  always_comb begin
    w_result = '0;
    case (w_op)
      OP_ADD:  w_result = w_a + w_b;
      OP_SUB:  w_result = w_a - w_b;
      OP_MUL:  w_result = w_a * w_b;
      OP_AND:  w_result = w_a & w_b;
      OP_OR:   w_result = w_a | w_b;
      OP_XOR:  w_result = w_a ^ w_b;
      OP_SHL:  w_result = w_a << w_b[SH_W-1:0];
      OP_SHR:  w_result = w_a >> w_b[SH_W-1:0];
      OP_PASS: w_result = w_a;
      OP_SMIN: w_result = ($signed(w_a) < $signed(w_b)) ? w_a : w_b;
      default: w_result = '0;
    endcase
  end

  assign w_acc_sum = r_acc + w_a + w_b;

  logic       w_is_acc;
  logic [7:0] w_acc_last;
  logic       w_acc_final;
  logic       w_need_slot;
  logic       w_slot_free;
  logic       w_fire;
  logic       w_emit;

  // Only beats that produce a result need the output slot; inner ACC beats proceed regardless.
  assign w_is_acc    = (w_op == OP_ACC);
  assign w_acc_last  = (w_acc_len == 8'd0) ? 8'd0 : (w_acc_len - 8'd1);
  assign w_acc_final = (r_cnt == w_acc_last);
  assign w_need_slot = ~w_is_acc | w_acc_final;
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_fire      = ~config_en & w_a_ok & w_b_ok & (~w_need_slot | w_slot_free);
  assign w_emit      = w_fire & w_need_slot;

  // A channel referenced by both operands is still popped only once.
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      w_pop[i] = w_fire & ((int'(w_sel_a) == i) | (int'(w_sel_b) == i));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cfg <= '0;
    end else if (config_en) begin
      r_cfg <= {r_cfg[CFG_W-2:0], config_in};
    end
  end

  // Holding acc/cnt clear while shifting leaves them zero on the first cycle after config.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (config_en) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_fire && w_is_acc) begin
      if (w_acc_final) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_acc_sum;
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_emit) begin
      r_out_data  <= w_is_acc ? w_acc_sum : w_result;
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

endmodule

// File: doc/elastic_pe.md
Name: elastic_pe

Overview:
- Parametrised successor to the fixed two-input ALU/MEM processing element.
- Has NUM_IN elastic input channels, each with valid/ready and its own FIFO.
- Runs a configurable ALU with an accumulate mode and drives one registered valid/ready output.
- Configuration is a serial shift chain clocked on the datapath clock. Instances daisy-chain config_in to config_out across the CGRA fabric.

Parameters:
- WIDTH, 32, datapath width in bits.
- NUM_IN, 2, number of input channels (2..8).
- FIFO_DEPTH, 2, entries per input FIFO (power of two, at least 2).
- SEL_W, $clog2(NUM_IN+1), operand-select field width.
- CFG_W, 12+2*SEL_W, config register width.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- config_en  in  1  shift enable for the config chain.
- config_in  in  1  serial config input.
- config_out  out  1  serial config output, equal to cfg[CFG_W-1].
- in_data  in  NUM_IN*WIDTH  packed channel data; channel i is bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready; equals "FIFO i not full".
- out_data  out  WIDTH  result.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream ready.

Behaviour:
- Reset (reset=0, asynchronous):
  - cfg, all FIFOs, acc, beat counter and out_valid clear to 0.
  - out_data clears to 0.
  - in_ready reads 1 once reset deasserts. While reset=0, in_ready is 0.
  - Reset asserted mid-operation discards all buffered data.
- Config register field layout:
  - op = cfg[3:0]
  - sel_a = cfg[4 +: SEL_W]
  - sel_b = cfg[4+SEL_W +: SEL_W]
  - acc_len = cfg[4+2*SEL_W +: 8]
- Config shift: while config_en=1, each cycle cfg <= {cfg[CFG_W-2:0], config_in}.
  - No FIFO pops and no fire occur. in_ready stays "not full", so pushes still occur.
  - The output register holds its value.
  - Accumulator and beat counter clear on the cycle config_en falls.
- Operand select:
  - sel < NUM_IN picks the head of FIFO sel.
  - sel >= NUM_IN gives constant 0, always available, never popped.
  - sel_a == sel_b < NUM_IN uses the same head for both operands and pops once.
- Fire condition: config_en=0, every referenced FIFO non-empty, and (out_valid=0 or out_ready=1).
  - On fire, each referenced FIFO pops exactly once.
- FIFO push: occurs when in_valid & in_ready.
  - Push and pop in the same cycle on a full FIFO is not allowed, because in_ready=0 when full (no bypass).
  - Push and pop in the same cycle on a non-full FIFO keeps the count unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Minimum latency from in_valid to out_valid is 2 cycles: 1 cycle FIFO write, then the fire cycle registers the output.
- Ops (a, b unsigned unless noted):
  - 0 ADD a+b
  - 1 SUB a-b
  - 2 MUL low WIDTH bits of a*b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 SHL a<<b[$clog2(WIDTH)-1:0]
  - 7 SHR logical
  - 8 PASS a
  - 9 SMIN, signed min(a,b)
  - 10 ACC, accumulate mode (below)
  - 11-15 reserved: result 0, still fires and emits.
  - All arithmetic is modulo 2^WIDTH with no saturation.
- Non-ACC fire: out_data <= result and out_valid <= 1 on the same edge.
- ACC mode:
  - Each fire sets acc <= acc + a + b and cnt <= cnt + 1.
  - When cnt == max(acc_len,1)-1, that fire also sets out_data <= acc+a+b and out_valid <= 1, then clears acc and cnt to 0.
  - Non-final ACC fires do not set out_valid and need only the operand condition; an occupied, stalled output does not block them.
  - The final beat requires the output slot free.
- Output handshake: out_valid clears when out_valid & out_ready and no new result is loaded that cycle. Back-to-back fire with out_ready=1 sustains 1 result per cycle.
- Simultaneous events:
  - config_en takes priority over fire.
  - Reset takes priority over everything.

Test Plan:
- Reset, then shift cfg op=0, sel_a=0, sel_b=1. Push ch0=5, ch1=7 with out_ready=1 → out_data=12 with out_valid high 2 cycles after the pushes; in_ready back to 1.
- op=1, ch0=3, ch1=5 → out_data=0xFFFFFFFE. op=9 with a=0xFFFFFFFF, b=1 → out_data=0xFFFFFFFF.
- ACC, acc_len=4, sel_b=NUM_IN (constant 0), push ch0 values 1,2,3,4 → exactly one output of 10. Repeat the sequence → 10 again, confirming acc cleared.
- out_ready=0 with FIFO_DEPTH=2: push 4 pairs of ADD operands → in_ready drops after 3 accepted per channel (2 in FIFO, 1 in output register). Release out_ready → 3 correct results in order, no loss or duplication.
- sel_a=sel_b=0, op=0, push ch0=9 → out 18, ch0 FIFO popped once; ch1 untouched.
- Assert reset low mid-stream with 2 entries buffered and out_valid=1 → out_valid=0 and out_data=0 immediately; after release, cfg=0 and no stale results appear.
